// File: rtl/ebr_port_arbiter.sv
// ----------------------------------------------------------------------------
// ebr_port_arbiter
// Shares one port of a DP8KC EBR (9-bit data, 13-bit address) between two
// fabric requesters. Round-robin arbitration issues at most one command per
// clock, and read data is returned with the requester's valid pulse after the
// EBR read latency. After system reset the EBR port reset is held asserted for
// RST_CYCLES clocks, and no grant is issued until that sequence completes.
//
// Parameters
//   AW          address width
//   DW          data width
//   READ_LAT    EBR read latency: 1 (REGMODE NOREG) or 2 (REGMODE OUTREG) only
//   RST_CYCLES  clocks EBR_RST stays high after rstn_i deasserts (>= 1)
//   CS_VAL      value driven on the EBR chip selects (matches CSDECODE)
//
// Ports
//   clk_i                 clock, shared with the EBR CLK pin
//   rstn_i                asynchronous active-low reset
//   req0_i / req1_i       request, command held stable until its grant
//   we0_i / we1_i         1 = write, 0 = read
//   addr0_i / addr1_i     command address
//   wdata0_i / wdata1_i   write data
//   gnt0_o / gnt1_o       combinational grant; command taken on this edge
//   rvalid0_o / rvalid1_o one-cycle read-data-valid pulse per read
//   rdata_o               shared read data, qualified by rvalidN_o
//   ready_o               high once EBR reset sequencing is complete
//   ebr_ce_o, ebr_oce_o, ebr_we_o, ebr_cs_o, ebr_rst_o,
//   ebr_ad_o, ebr_di_o    drive the EBR port pins
//   ebr_do_i              read data from the EBR
// ----------------------------------------------------------------------------
module ebr_port_arbiter #(
    parameter int          AW         = 13,
    parameter int          DW         = 9,
    parameter int          READ_LAT   = 1,
    parameter int          RST_CYCLES = 4,
    parameter logic [2:0]  CS_VAL     = 3'b000
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          req0_i,
    input  logic          req1_i,
    input  logic          we0_i,
    input  logic          we1_i,
    input  logic [AW-1:0] addr0_i,
    input  logic [AW-1:0] addr1_i,
    input  logic [DW-1:0] wdata0_i,
    input  logic [DW-1:0] wdata1_i,
    output logic          gnt0_o,
    output logic          gnt1_o,
    output logic          rvalid0_o,
    output logic          rvalid1_o,
    output logic [DW-1:0] rdata_o,
    output logic          ready_o,
    output logic          ebr_ce_o,
    output logic          ebr_oce_o,
    output logic          ebr_we_o,
    output logic [2:0]    ebr_cs_o,
    output logic          ebr_rst_o,
    output logic [AW-1:0] ebr_ad_o,
    output logic [DW-1:0] ebr_di_o,
    input  logic [DW-1:0] ebr_do_i
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int            CW       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(RST_CYCLES - 1);

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 rr_q, rr_d;       // 1 = requester 1 has priority
    logic [AW-1:0]        ad_q, ad_d;
    logic [DW-1:0]        di_q, di_d;
    logic [READ_LAT-1:0]  pv_q, pv_d;       // read-return valid pipeline
    logic [READ_LAT-1:0]  pid_q, pid_d;     // requester id riding with pv

    logic                 run_s;
    logic                 gnt0_s, gnt1_s;
    logic                 win_we_s;
    logic [AW-1:0]        win_ad_s;
    logic [DW-1:0]        win_di_s;
    logic                 rd_push_s;

    // State, counter, round-robin pointer, held command and read pipeline
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            rr_q    <= 1'b0;
            ad_q    <= '0;
            di_q    <= '0;
            pv_q    <= '0;
            pid_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            ad_q    <= ad_d;
            di_q    <= di_d;
            pv_q    <= pv_d;
            pid_q   <= pid_d;
        end
    end

    // Next-state: count out the EBR reset window, then stay in RUN
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // State decode: RUN opens arbitration and releases the EBR reset
    always_comb begin
        run_s = 1'b0;
        case (state_q)
            ST_RUN:  run_s = 1'b1;
            ST_INIT: run_s = 1'b0;
            default: run_s = 1'b0;
        endcase
    end

    // Round-robin arbitration; the pointer hands priority to the loser
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        rr_d   = rr_q;
        if (run_s) begin
            if (req0_i && (!req1_i || !rr_q)) begin
                gnt0_s = 1'b1;
                rr_d   = 1'b1;
            end else if (req1_i) begin
                gnt1_s = 1'b1;
                rr_d   = 1'b0;
            end else begin
                rr_d   = rr_q;
            end
        end else begin
            rr_d = rr_q;
        end
    end

    // Command mux; with no grant the address/data pins keep the last command
    always_comb begin
        win_we_s = 1'b0;
        win_ad_s = ad_q;
        win_di_s = di_q;
        if (gnt1_s) begin
            win_we_s = we1_i;
            win_ad_s = addr1_i;
            win_di_s = wdata1_i;
        end else if (gnt0_s) begin
            win_we_s = we0_i;
            win_ad_s = addr0_i;
            win_di_s = wdata0_i;
        end else begin
            win_we_s = 1'b0;
        end
        ad_d = win_ad_s;
        di_d = win_di_s;
    end

    // Read pipeline: a granted read enters at bit 0 and emerges READ_LAT
    // edges later, carrying the id of the requester it belongs to
    always_comb begin
        rd_push_s = (gnt0_s | gnt1_s) & ~win_we_s;
        pv_d      = READ_LAT'({pv_q, rd_push_s});
        pid_d     = READ_LAT'({pid_q, gnt1_s});
    end

    assign gnt0_o    = gnt0_s;
    assign gnt1_o    = gnt1_s;
    assign ebr_ce_o  = gnt0_s | gnt1_s;
    assign ebr_we_o  = (gnt0_s | gnt1_s) & win_we_s;
    assign ebr_ad_o  = win_ad_s;
    assign ebr_di_o  = win_di_s;
    assign ebr_oce_o = run_s;
    assign ebr_rst_o = ~run_s;
    assign ready_o   = run_s;
    assign ebr_cs_o  = CS_VAL;
    assign rvalid0_o = pv_q[READ_LAT-1] & ~pid_q[READ_LAT-1];
    assign rvalid1_o = pv_q[READ_LAT-1] &  pid_q[READ_LAT-1];
    assign rdata_o   = ebr_do_i;

endmodule

// File: tb/tb_ebr_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ebr_port_arbiter
// Drives two arbiter instances (READ_LAT=1 and READ_LAT=2) from the same
// stimulus, each attached to its own behavioural EBR. Hand-written vector
// table for the directed corner cases, then randomized traffic with
// occasional resets, all checked against a transaction-level reference model.
// ----------------------------------------------------------------------------
module tb_ebr_port_arbiter;

    localparam int RSTC = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [12:0] addr0 = 13'h0, addr1 = 13'h0;
    logic [8:0]  wdata0 = 9'h0, wdata1 = 9'h0;

    logic        g0 [2], g1 [2], rv0 [2], rv1 [2], rdy [2];
    logic        ce [2], oce [2], we [2], rst [2];
    logic [2:0]  cs [2];
    logic [12:0] ad [2];
    logic [8:0]  di [2], rdat [2], edo [2];

    always #5 clk = ~clk;

    ebr_port_arbiter #(.READ_LAT(1), .RST_CYCLES(RSTC)) u_lat1 (
        .clk_i(clk), .rstn_i(rstn), .req0_i(req0), .req1_i(req1),
        .we0_i(we0), .we1_i(we1), .addr0_i(addr0), .addr1_i(addr1),
        .wdata0_i(wdata0), .wdata1_i(wdata1), .gnt0_o(g0[0]), .gnt1_o(g1[0]),
        .rvalid0_o(rv0[0]), .rvalid1_o(rv1[0]), .rdata_o(rdat[0]), .ready_o(rdy[0]),
        .ebr_ce_o(ce[0]), .ebr_oce_o(oce[0]), .ebr_we_o(we[0]), .ebr_cs_o(cs[0]),
        .ebr_rst_o(rst[0]), .ebr_ad_o(ad[0]), .ebr_di_o(di[0]), .ebr_do_i(edo[0]));

    ebr_port_arbiter #(.READ_LAT(2), .RST_CYCLES(RSTC)) u_lat2 (
        .clk_i(clk), .rstn_i(rstn), .req0_i(req0), .req1_i(req1),
        .we0_i(we0), .we1_i(we1), .addr0_i(addr0), .addr1_i(addr1),
        .wdata0_i(wdata0), .wdata1_i(wdata1), .gnt0_o(g0[1]), .gnt1_o(g1[1]),
        .rvalid0_o(rv0[1]), .rvalid1_o(rv1[1]), .rdata_o(rdat[1]), .ready_o(rdy[1]),
        .ebr_ce_o(ce[1]), .ebr_oce_o(oce[1]), .ebr_we_o(we[1]), .ebr_cs_o(cs[1]),
        .ebr_rst_o(rst[1]), .ebr_ad_o(ad[1]), .ebr_di_o(di[1]), .ebr_do_i(edo[1]));

    // Power-up EBR contents: 0x1A0 + address (so address 5 reads 0x1A5)
    function automatic logic [8:0] init_val(int a);
        return 9'(a) + 9'h1A0;
    endfunction

    // Behavioural EBRs: NOREG for instance 0, OUTREG (extra stage) for instance 1
    logic [8:0] mem_a [int];
    logic [8:0] mem_b [int];
    logic [8:0] stage_b = 9'h0;
    initial edo[0] = 9'h0;
    initial edo[1] = 9'h0;
    always @(posedge clk) begin
        if (ce[0]) begin
            if (we[0]) mem_a[int'(ad[0])] = di[0];
            else edo[0] <= mem_a.exists(int'(ad[0])) ? mem_a[int'(ad[0])] : init_val(int'(ad[0]));
        end
        if (ce[1]) begin
            if (we[1]) mem_b[int'(ad[1])] = di[1];
            else stage_b <= mem_b.exists(int'(ad[1])) ? mem_b[int'(ad[1])] : init_val(int'(ad[1]));
        end
        edo[1] <= stage_b;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s lat%0d @%0t: got %0h expected %0h", name, k + 1, $time, act, exp);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    typedef struct { int gc; bit id; logic [8:0] d; } rd_t;
    rd_t        rq [$];          // reads in grant order, tagged with grant cycle
    logic [8:0] refm [int];
    int         cyc = 0;
    int         since_rel = 0;   // clock edges seen with reset released
    int         last_win = 1;    // requester served last; the other has priority
    int         m_win = -1;      // winner of the current cycle, -1 = none
    logic [12:0] last_ad = 13'h0;
    logic [8:0]  last_di = 9'h0;

    task automatic model_check();
        bit         ready_e;
        bit         wwe;
        logic [12:0] wad;
        logic [8:0]  wdi;
        bit         v0e, v1e;
        logic [8:0] de;
        if (!rstn) begin
            since_rel = 0; rq.delete(); last_win = 1; last_ad = 13'h0; last_di = 9'h0;
        end
        ready_e = (since_rel >= RSTC);
        m_win = -1;
        if (ready_e) begin
            if (req0 && req1) m_win = (last_win == 0) ? 1 : 0;
            else if (req0)    m_win = 0;
            else if (req1)    m_win = 1;
        end
        wwe = 1'b0; wad = last_ad; wdi = last_di;
        if (m_win == 0) begin wwe = we0; wad = addr0; wdi = wdata0; end
        if (m_win == 1) begin wwe = we1; wad = addr1; wdi = wdata1; end
        for (int k = 0; k < 2; k++) begin
            v0e = 1'b0; v1e = 1'b0; de = 9'h0;
            foreach (rq[i]) begin
                if (rq[i].gc == cyc - (k + 1)) begin
                    if (rq[i].id) v1e = 1'b1; else v0e = 1'b1;
                    de = rq[i].d;
                end
            end
            chk("gnt0", k, 32'(g0[k]), 32'(m_win == 0));
            chk("gnt1", k, 32'(g1[k]), 32'(m_win == 1));
            chk("ready", k, 32'(rdy[k]), 32'(ready_e));
            chk("ebr_rst", k, 32'(rst[k]), 32'(!ready_e));
            chk("ebr_oce", k, 32'(oce[k]), 32'(ready_e));
            chk("ebr_ce", k, 32'(ce[k]), 32'(m_win >= 0));
            chk("ebr_we", k, 32'(we[k]), 32'(wwe));
            chk("ebr_cs", k, 32'(cs[k]), 32'(3'b000));
            chk("ebr_ad", k, 32'(ad[k]), 32'(wad));
            chk("ebr_di", k, 32'(di[k]), 32'(wdi));
            chk("rvalid0", k, 32'(rv0[k]), 32'(v0e));
            chk("rvalid1", k, 32'(rv1[k]), 32'(v1e));
            if (v0e || v1e) chk("rdata", k, 32'(rdat[k]), 32'(de));
        end
    endtask

    task automatic model_advance();
        int         a;
        logic [8:0] d;
        rd_t        r;
        if (rstn) begin
            if (m_win >= 0) begin
                last_win = m_win;
                a = (m_win == 1) ? int'(addr1) : int'(addr0);
                d = (m_win == 1) ? wdata1 : wdata0;
                last_ad = 13'(a);
                last_di = d;
                if ((m_win == 1) ? we1 : we0) refm[a] = d;
                else begin
                    r.gc = cyc; r.id = (m_win == 1);
                    r.d = refm.exists(a) ? refm[a] : init_val(a);
                    rq.push_back(r);
                end
            end
            if (since_rel < 1000) since_rel++;
        end
        cyc++;
        while (rq.size() > 0 && rq[0].gc < cyc - 2) void'(rq.pop_front());
    endtask

    // Called right after inputs are driven on the falling edge
    task automatic tick();
        #1;
        model_check();
        model_advance();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic rstn, r0, w0; logic [12:0] a0; logic [8:0] d0;
        logic r1, w1; logic [12:0] a1; logic [8:0] d1;
        logic [1:0] eg; logic erdy, erst;          // eg = {gnt1, gnt0}
        logic [1:0] ev1; logic [8:0] ed1;          // ev = {rvalid1, rvalid0}
        logic [1:0] ev2; logic [8:0] ed2;
    } vec_t;
    vec_t tbl [$];

    function automatic vec_t mk(logic rs, logic r0, logic w0, logic [12:0] a0, logic [8:0] d0,
                                logic r1, logic w1, logic [12:0] a1, logic [8:0] d1,
                                logic [1:0] eg, logic erdy, logic erst,
                                logic [1:0] ev1, logic [8:0] ed1, logic [1:0] ev2, logic [8:0] ed2);
        vec_t v;
        v.rstn = rs; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.eg = eg; v.erdy = erdy; v.erst = erst;
        v.ev1 = ev1; v.ed1 = ed1; v.ev2 = ev2; v.ed2 = ed2;
        return v;
    endfunction

    // Idle cycle in RUN with expected read returns
    function automatic vec_t idle(logic [1:0] ev1, logic [8:0] ed1, logic [1:0] ev2, logic [8:0] ed2);
        return mk(1'b1, 1'b0, 1'b0, 13'h0, 9'h0, 1'b0, 1'b0, 13'h0, 9'h0,
                  2'b00, 1'b1, 1'b0, ev1, ed1, ev2, ed2);
    endfunction

    // Single read from one requester in RUN
    function automatic vec_t rd(logic id, logic [12:0] a, logic [1:0] ev1, logic [8:0] ed1,
                                logic [1:0] ev2, logic [8:0] ed2);
        return mk(1'b1, !id, 1'b0, a, 9'h0, id, 1'b0, a, 9'h0,
                  id ? 2'b10 : 2'b01, 1'b1, 1'b0, ev1, ed1, ev2, ed2);
    endfunction

    bit         p0 = 1'b0, p1 = 1'b0;
    logic       pw0, pw1;
    logic [12:0] pa0, pa1;
    logic [8:0]  pd0, pd1;

    initial begin
        // Reset, then requester 0 waits through INIT with a read of 0x005 pending
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 13'h005, 9'h0, 1'b0, 1'b0, 13'h0, 9'h0,
                         2'b00, 1'b0, 1'b1, 2'b00, 9'h0, 2'b00, 9'h0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1'b1, 1'b1, 1'b0, 13'h005, 9'h0, 1'b0, 1'b0, 13'h0, 9'h0,
                             2'b00, 1'b0, 1'b1, 2'b00, 9'h0, 2'b00, 9'h0));
        tbl.push_back(rd(1'b0, 13'h005, 2'b00, 9'h0, 2'b00, 9'h0));
        tbl.push_back(idle(2'b01, 9'h1A5, 2'b00, 9'h0));
        tbl.push_back(idle(2'b00, 9'h0, 2'b01, 9'h1A5));
        // Requester 1 alone for three cycles
        tbl.push_back(rd(1'b1, 13'h003, 2'b00, 9'h0, 2'b00, 9'h0));
        tbl.push_back(rd(1'b1, 13'h004, 2'b10, 9'h1A3, 2'b00, 9'h0));
        tbl.push_back(rd(1'b1, 13'h006, 2'b10, 9'h1A4, 2'b10, 9'h1A3));
        // Both requesting for six cycles: strict alternation starting with 0
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 13'h001, 9'h0, 1'b1, 1'b0, 13'h002, 9'h0,
                         2'b01, 1'b1, 1'b0, 2'b10, 9'h1A6, 2'b10, 9'h1A4));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 13'h001, 9'h0, 1'b1, 1'b0, 13'h002, 9'h0,
                         2'b10, 1'b1, 1'b0, 2'b01, 9'h1A1, 2'b10, 9'h1A6));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1'b1, 1'b1, 1'b0, 13'h001, 9'h0, 1'b1, 1'b0, 13'h002, 9'h0,
                             (i % 2 == 0) ? 2'b01 : 2'b10, 1'b1, 1'b0,
                             (i % 2 == 0) ? 2'b10 : 2'b01, (i % 2 == 0) ? 9'h1A2 : 9'h1A1,
                             (i % 2 == 0) ? 2'b01 : 2'b10, (i % 2 == 0) ? 9'h1A1 : 9'h1A2));
        tbl.push_back(idle(2'b10, 9'h1A2, 2'b01, 9'h1A1));
        tbl.push_back(idle(2'b00, 9'h0, 2'b10, 9'h1A2));
        // Requester 1 writes 0x0F3 to 0x007 then reads it back
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 13'h0, 9'h0, 1'b1, 1'b1, 13'h007, 9'h0F3,
                         2'b10, 1'b1, 1'b0, 2'b00, 9'h0, 2'b00, 9'h0));
        tbl.push_back(rd(1'b1, 13'h007, 2'b00, 9'h0, 2'b00, 9'h0));
        tbl.push_back(idle(2'b10, 9'h0F3, 2'b00, 9'h0));
        tbl.push_back(idle(2'b00, 9'h0, 2'b10, 9'h0F3));
        // Two reads in flight, then reset drops them and reruns INIT
        tbl.push_back(rd(1'b0, 13'h008, 2'b00, 9'h0, 2'b00, 9'h0));
        tbl.push_back(rd(1'b1, 13'h009, 2'b01, 9'h1A8, 2'b00, 9'h0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 13'h005, 9'h0, 1'b0, 1'b0, 13'h0, 9'h0,
                         2'b00, 1'b0, 1'b1, 2'b00, 9'h0, 2'b00, 9'h0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1'b1, 1'b1, 1'b0, 13'h005, 9'h0, 1'b0, 1'b0, 13'h0, 9'h0,
                             2'b00, 1'b0, 1'b1, 2'b00, 9'h0, 2'b00, 9'h0));
        tbl.push_back(rd(1'b0, 13'h005, 2'b00, 9'h0, 2'b00, 9'h0));
        tbl.push_back(idle(2'b01, 9'h1A5, 2'b00, 9'h0));
        tbl.push_back(idle(2'b00, 9'h0, 2'b01, 9'h1A5));

        foreach (tbl[i]) begin
            @(negedge clk);
            rstn = tbl[i].rstn;
            req0 = tbl[i].r0; we0 = tbl[i].w0; addr0 = tbl[i].a0; wdata0 = tbl[i].d0;
            req1 = tbl[i].r1; we1 = tbl[i].w1; addr1 = tbl[i].a1; wdata1 = tbl[i].d1;
            tick();
            for (int k = 0; k < 2; k++) begin
                chk("tbl_gnt", k, 32'({g1[k], g0[k]}), 32'(tbl[i].eg));
                chk("tbl_ready", k, 32'(rdy[k]), 32'(tbl[i].erdy));
                chk("tbl_ebr_rst", k, 32'(rst[k]), 32'(tbl[i].erst));
                chk("tbl_rvalid", k, 32'({rv1[k], rv0[k]}), 32'((k == 0) ? tbl[i].ev1 : tbl[i].ev2));
                if (((k == 0) ? tbl[i].ev1 : tbl[i].ev2) != 2'b00)
                    chk("tbl_rdata", k, 32'(rdat[k]), 32'((k == 0) ? tbl[i].ed1 : tbl[i].ed2));
            end
        end

        // Randomized traffic: commands held until granted, occasional resets
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            rstn = ($urandom_range(0, 299) != 0);
            if (!p0 && $urandom_range(0, 9) < 6) begin
                p0 = 1'b1; pw0 = ($urandom_range(0, 9) < 3);
                pa0 = 13'($urandom_range(0, 15)); pd0 = 9'($urandom);
            end
            if (!p1 && $urandom_range(0, 9) < 6) begin
                p1 = 1'b1; pw1 = ($urandom_range(0, 9) < 3);
                pa1 = 13'($urandom_range(0, 15)); pd1 = 9'($urandom);
            end
            req0 = p0; we0 = pw0; addr0 = pa0; wdata0 = pd0;
            req1 = p1; we1 = pw1; addr1 = pa1; wdata1 = pd1;
            tick();
            if (m_win == 0) p0 = 1'b0;
            if (m_win == 1) p1 = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
